// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the opcode values are also used by the controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {PC, instruction} pairs with a whole-buffer flush.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic [PC_WIDTH-1:0]              push_pc,
  input  logic [31:0]                      push_instr,
  input  logic                             pop,
  output logic [PC_WIDTH-1:0]              head_pc,
  output logic [31:0]                      head_instr,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [31:0]         instr_mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC ownership, credit-limited imem requests, in-order
// response buffering and redirect flush with stale-response dropping.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                Redirect,
  input  logic [PC_WIDTH-1:0] RedirectPC,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         Instruction,
  output logic [PC_WIDTH-1:0] InstPC,
  output logic [6:0]          Opcode
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] CAP = (CW+1)'(FIFO_DEPTH);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] rsp_pc;
  logic [PC_WIDTH-1:0] target;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       drop_cnt;
  logic [CW-1:0]       out_next;
  logic [CW-1:0]       buf_count;
  logic [PC_WIDTH-1:0] head_pc;
  logic [31:0]         head_instr;
  logic                fire;
  logic                rsp;
  logic                push;
  logic                pop;

  // Credit covers both in-flight and buffered entries, so the buffer cannot overflow.
  assign imem_req_valid = (state == RUN) && (({1'b0, outstanding} + {1'b0, buf_count}) < CAP);
  assign imem_req_addr  = fetch_pc;

  assign fire     = imem_req_valid && imem_req_ready;
  assign rsp      = imem_rsp_valid && (outstanding != '0);
  assign push     = rsp && (drop_cnt == '0) && !Redirect;
  assign pop      = inst_valid && inst_ready;
  assign out_next = outstanding + CW'(fire) - CW'(rsp);
  assign target   = RedirectPC & ~PC_WIDTH'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (Redirect) begin
        // Everything still owed by memory after this cycle is stale.
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= out_next;
        state    <= (out_next != '0) ? FLUSH : RUN;
      end else begin
        if (fire) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (push) rsp_pc   <= rsp_pc + PC_WIDTH'(4);
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= RUN;
          FLUSH: begin
            if ((drop_cnt == '0) || (rsp && (drop_cnt == CW'(1)))) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_buffer #(
    .DEPTH    (FIFO_DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (Redirect),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_instr (imem_rsp_data),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (buf_count)
  );

  assign inst_valid  = (buf_count != '0);
  assign Instruction = inst_valid ? head_instr : NOP_INSTR;
  assign InstPC      = inst_valid ? head_pc : '0;
  assign Opcode      = Instruction[6:0];

endmodule
